// File: rtl/output_spike_packetizer.sv
// Packs a per-neuron spike stream into 40-bit bitmaps and emits 57-bit NoC packets, one per 40 neurons.
// Latency: accepting the beat that completes a word -> pkt_valid high on the next cycle.
// Backpressure: spk_ready drops while a packet waits for pkt_ready; ts_ready is high only in IDLE.
// Optional: OUTPUT_SPIKE_PACKETIZER_COUNT_EN adds spk_count, a per-timestep count of 1-valued spikes.
module output_spike_packetizer #(
  parameter int          DEPTH_C  = 441,
  parameter int          ADDR_C   = 9,
  parameter int          DATA_W   = 40,
  parameter int          PACKET_W = 57,
  parameter logic [3:0]  SRC_ID   = 4'd14,
  parameter logic [3:0]  DEST_ID  = 4'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ts_valid,
  output logic                ts_ready,
  input  logic [1:0]          ts_in,
  input  logic [1:0]          layer_in,
  input  logic                spk_valid,
  output logic                spk_ready,
  input  logic [ADDR_C-1:0]   spk_addr,
  input  logic                spk_bit,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [PACKET_W-1:0] pkt_data,
  output logic                ts_done,
  output logic                err_seq
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
  , output logic [ADDR_C:0]   spk_count
`endif
);

  // Word geometry: the last word of a timestep is partially filled and zero-padded.
  localparam int NWORDS = (DEPTH_C + DATA_W - 1) / DATA_W;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 6;

  localparam logic [ADDR_C-1:0] ADDR_ONE  = ADDR_C'(1);
  localparam logic [ADDR_C-1:0] ADDR_LAST = ADDR_C'(DEPTH_C - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ts_q, ts_d;
  logic [1:0]          layer_q, layer_d;
  logic [DATA_W-1:0]   bitmap_q, bitmap_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [ADDR_C-1:0]   exp_addr_q, exp_addr_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic [PACKET_W-1:0] pkt_data_q, pkt_data_d;
  logic                ts_done_q, ts_done_d;
  logic                err_seq_q, err_seq_d;

  logic ts_xfer;
  logic spk_xfer;
  logic pkt_xfer;
  logic word_full;
  logic last_word;

  // A word closes on its 40th bit or on the final neuron of the timestep.
  assign word_full = (bit_cnt_q == CNT_LAST) || (exp_addr_q == ADDR_LAST);
  assign last_word = (word_idx_q == IDX_LAST);

  assign ts_xfer  = ts_valid  && ts_ready;
  assign spk_xfer = spk_valid && spk_ready;
  assign pkt_xfer = pkt_valid_q && pkt_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> COLLECT on tag, COLLECT -> EMIT on word close, EMIT -> COLLECT/IDLE on accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ts_xfer) state_d = COLLECT;
      end
      COLLECT: begin
        if (spk_xfer && word_full) state_d = EMIT;
      end
      EMIT: begin
        if (pkt_xfer) state_d = last_word ? IDLE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on the current state.
  always_comb begin
    ts_ready  = 1'b0;
    spk_ready = 1'b0;
    unique case (state_q)
      IDLE:    ts_ready  = 1'b1;
      COLLECT: spk_ready = 1'b1;
      default: begin
        ts_ready  = 1'b0;
        spk_ready = 1'b0;
      end
    endcase
  end

  // Datapath next-state: tag latch, bit packing, packet build and word advance.
  always_comb begin
    ts_d        = ts_q;
    layer_d     = layer_q;
    bitmap_d    = bitmap_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    exp_addr_d  = exp_addr_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    ts_done_d   = 1'b0;
    err_seq_d   = err_seq_q;

    if (ts_xfer) begin
      ts_d       = ts_in;
      layer_d    = layer_in;
      bitmap_d   = '0;
      bit_cnt_d  = '0;
      word_idx_d = '0;
      exp_addr_d = '0;
    end

    if (spk_xfer) begin
      // Bit position follows beat order, not the address, so a misaddressed beat still lands in sequence.
      bitmap_d   = bitmap_q | ({{(DATA_W-1){1'b0}}, spk_bit} << bit_cnt_q);
      bit_cnt_d  = bit_cnt_q + CNT_ONE;
      exp_addr_d = exp_addr_q + ADDR_ONE;
      if (spk_addr != exp_addr_q) err_seq_d = 1'b1;
      if (word_full) begin
        pkt_data_d  = {1'b0, SRC_ID, DEST_ID, ts_q, layer_q, word_idx_q, bitmap_d};
        pkt_valid_d = 1'b1;
      end
    end

    if (pkt_xfer) begin
      pkt_valid_d = 1'b0;
      if (last_word) begin
        ts_done_d = 1'b1;
      end else begin
        bitmap_d   = '0;
        bit_cnt_d  = '0;
        word_idx_d = word_idx_q + IDX_ONE;
      end
    end
  end

  // Datapath registers; reset drops any in-flight packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      layer_q     <= '0;
      bitmap_q    <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      exp_addr_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      ts_done_q   <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      layer_q     <= layer_d;
      bitmap_q    <= bitmap_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      exp_addr_q  <= exp_addr_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      ts_done_q   <= ts_done_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign ts_done   = ts_done_q;
  assign err_seq   = err_seq_q;

`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
  localparam logic [ADDR_C:0] SCNT_ONE = (ADDR_C+1)'(1);

  logic [ADDR_C:0] spk_count_q, spk_count_d;

  // Count of 1-valued spikes this timestep; holds its final value until the next tag.
  always_comb begin
    spk_count_d = spk_count_q;
    if (ts_xfer) begin
      spk_count_d = '0;
    end else if (spk_xfer && spk_bit) begin
      spk_count_d = spk_count_q + SCNT_ONE;
    end
  end

  // Spike counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_count_q <= '0;
    end else begin
      spk_count_q <= spk_count_d;
    end
  end

  assign spk_count = spk_count_q;
`endif

endmodule

// File: tb/tb_output_spike_packetizer.sv
// Directed + randomized bench for output_spike_packetizer against a timestep-level packet model.
module tb_output_spike_packetizer;

  localparam int DEPTH = 441;
  localparam int DW    = 40;
  localparam int NW    = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ts_valid = 1'b0;
  logic        ts_ready;
  logic [1:0]  ts_in = '0;
  logic [1:0]  layer_in = '0;
  logic        spk_valid = 1'b0;
  logic        spk_ready;
  logic [8:0]  spk_addr = '0;
  logic        spk_bit = 1'b0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [56:0] pkt_data;
  logic        ts_done;
  logic        err_seq;
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
  logic [9:0]  spk_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit beat_bits [DEPTH];
  bit err_exp = 1'b0;

  always #5 clk = ~clk;

  output_spike_packetizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_in     (ts_in),
    .layer_in  (layer_in),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_addr  (spk_addr),
    .spk_bit   (spk_bit),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .ts_done   (ts_done),
    .err_seq   (err_seq)
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
    , .spk_count (spk_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected packet for word w: bit j carries the (w*40+j)-th beat of the timestep, padded with zeros.
  function automatic logic [56:0] model_pkt(input logic [1:0] ts, input logic [1:0] layer, input int w);
    logic [39:0] bm;
    bm = '0;
    for (int j = 0; j < DW; j++)
      if (w * DW + j < DEPTH) bm[j] = beat_bits[w * DW + j];
    return {1'b0, 4'd14, 4'd0, ts, layer, 4'(w), bm};
  endfunction

  function automatic int ones_in_beats();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(beat_bits[i]);
    return n;
  endfunction

  // Present a tag in IDLE and wait (bounded) until it is taken.
  task automatic send_ts(input logic [1:0] ts, input logic [1:0] layer);
    bit took;
    took = 1'b0;
    ts_valid = 1'b1;
    ts_in    = ts;
    layer_in = layer;
    for (int c = 0; c < 20 && !took; c++) begin
      took = ts_ready;
      @(posedge clk); #1;
    end
    ts_valid = 1'b0;
    check("ts_accept", 64'(took), 64'(1));
    check("ts_ready_collect", 64'(ts_ready), 64'(0));
    check("spk_ready_collect", 64'(spk_ready), 64'(1));
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
    check("spk_count_clear", 64'(spk_count), 64'(0));
`endif
  endtask

  // Stream one whole timestep; mode 0: pkt_ready=1, 1: random, 2: 10-cycle stall on first packet.
  task automatic run_ts(input logic [1:0] ts, input logic [1:0] layer, input int mode,
                        input int gap_at, input bit ts_noise);
    int  beat, pkts, stall, a;
    bit  spk_x, pkt_x, done_exp, pv_exp, finished;
    logic [8:0] drv_addr;
    send_ts(ts, layer);
    beat = 0; pkts = 0; stall = 0; finished = 1'b0;
    ts_valid = ts_noise;
    ts_in    = 2'd3;
    layer_in = 2'd3;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      a        = (gap_at >= 0 && beat >= gap_at) ? beat + 1 : beat;
      drv_addr = 9'(a);
      spk_valid = (beat < DEPTH) && ($urandom_range(0, 3) != 0);
      spk_addr  = drv_addr;
      spk_bit   = (beat < DEPTH) ? beat_bits[beat] : 1'b0;
      if (mode == 0) pkt_ready = 1'b1;
      else if (mode == 1) pkt_ready = 1'($urandom_range(0, 1));
      else if (pkt_valid && pkts == 0 && stall < 10) begin pkt_ready = 1'b0; stall++; end
      else pkt_ready = 1'b1;
      spk_x = spk_valid && spk_ready;
      pkt_x = pkt_valid && pkt_ready;
      @(posedge clk); #1;
      if (spk_x) begin
        if (int'(drv_addr) != beat) err_exp = 1'b1;
        beat++;
      end
      if (pkt_x) pkts++;
      done_exp = pkt_x && (pkts == NW);
      pv_exp   = (pkts < NW) && (beat >= (((pkts + 1) * DW < DEPTH) ? (pkts + 1) * DW : DEPTH));
      check("pkt_valid", 64'(pkt_valid), 64'(pv_exp));
      if (pv_exp) check($sformatf("pkt_data_w%0d", pkts), 64'(pkt_data), 64'(model_pkt(ts, layer, pkts)));
      check("spk_ready", 64'(spk_ready), 64'((pkts < NW) && !pv_exp));
      check("ts_ready", 64'(ts_ready), 64'(pkts == NW));
      check("ts_done", 64'(ts_done), 64'(done_exp));
      check("err_seq", 64'(err_seq), 64'(err_exp));
      if (pkts == NW) begin
        finished  = 1'b1;
        ts_valid  = 1'b0;
        spk_valid = 1'b0;
        pkt_ready = 1'b0;
      end
    end
    check("run_finished", 64'(finished), 64'(1));
    check("beats_consumed", 64'(beat), 64'(DEPTH));
    @(posedge clk); #1;
    check("ts_done_pulse_end", 64'(ts_done), 64'(0));
    check("pkt_valid_idle", 64'(pkt_valid), 64'(0));
    check("ts_ready_idle", 64'(ts_ready), 64'(1));
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
    check("spk_count_final", 64'(spk_count), 64'(ones_in_beats()));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ts_ready"}, 64'(ts_ready), 64'(1));
    check({tag, "_spk_ready"}, 64'(spk_ready), 64'(0));
    check({tag, "_pkt_valid"}, 64'(pkt_valid), 64'(0));
    check({tag, "_pkt_data"}, 64'(pkt_data), 64'(0));
    check({tag, "_ts_done"}, 64'(ts_done), 64'(0));
    check({tag, "_err_seq"}, 64'(err_seq), 64'(0));
`ifdef OUTPUT_SPIKE_PACKETIZER_COUNT_EN
    check({tag, "_spk_count"}, 64'(spk_count), 64'(0));
`endif
  endtask

  initial begin
    bit seen;
    // Power-on reset.
    rst_n = 1'b0;
    #17;
    check_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Even-address spikes, always-ready NoC.
    for (int i = 0; i < DEPTH; i++) beat_bits[i] = (i % 2 == 0);
    check("model_w0", 64'(model_pkt(2'd1, 2'd1, 0) & 57'hFF_FFFF_FFFF), 64'h55_5555_5555);
    check("model_w11", 64'(model_pkt(2'd1, 2'd1, 11) & 57'hFF_FFFF_FFFF), 64'h1);
    run_ts(2'd1, 2'd1, 0, -1, 1'b0);

    // ts=2 with a stalled first packet and a stray tag offered throughout.
    for (int i = 0; i < DEPTH; i++) beat_bits[i] = 1'($urandom_range(0, 1));
    run_ts(2'd2, 2'd2, 2, -1, 1'b1);

    // Address gap after beat 4: error is sticky and bits stay in beat order.
    for (int i = 0; i < DEPTH; i++) beat_bits[i] = 1'($urandom_range(0, 1));
    run_ts(2'd1, 2'd3, 1, 5, 1'b0);
    @(posedge clk); #1;
    check("err_seq_sticky", 64'(err_seq), 64'(1));

    // Reset while a packet is pending.
    send_ts(2'd1, 2'd0);
    seen = 1'b0;
    pkt_ready = 1'b0;
    for (int b = 0, c = 0; c < 200 && !seen; c++) begin
      spk_valid = 1'b1;
      spk_addr  = 9'(b);
      spk_bit   = 1'b1;
      if (spk_ready) b++;
      @(posedge clk); #1;
      seen = pkt_valid;
    end
    spk_valid = 1'b0;
    check("emit_reached", 64'(seen), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_emit");
    err_exp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones timestep after reset, random ready; then a fresh timestep clears the count.
    for (int i = 0; i < DEPTH; i++) beat_bits[i] = 1'b1;
    run_ts(2'd2, 2'd0, 1, -1, 1'b0);
    for (int i = 0; i < DEPTH; i++) beat_bits[i] = 1'($urandom_range(0, 1));
    run_ts(2'd1, 2'd2, 1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
